// File: rtl/trig_conditioner.sv
// Trigger conditioner: synchronises and debounces the raw trigger, emits edge
// pulses, counts rejected glitches and applies delay_timer configuration only
// while no trigger qualification is in progress.
module trig_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE_W  = 16,
  parameter int unsigned DEFAULT_DB  = 1000
) (
  input  logic                  clk,
  input  logic                  RESET_n,
  input  logic                  i_trig_raw,
  input  logic [DEBOUNCE_W-1:0] i_db_count,
  input  logic                  i_db_load,
  input  logic [7:0]            i_prog_wb,
  input  logic [1:0]            i_prog_ab,
  input  logic                  i_prog_strobe,
  output logic                  o_TRIG,
  output logic                  o_trig_rise,
  output logic                  o_trig_fall,
  output logic [7:0]            o_wb,
  output logic                  o_A,
  output logic                  o_B,
  output logic [7:0]            o_glitch_cnt
);

  // One extra bit so the incremented count can be compared without wrapping
  localparam int unsigned CW = DEBOUNCE_W + 1;

  typedef enum logic [1:0] {IDLE_LO, QUAL_HI, IDLE_HI, QUAL_LO} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DEBOUNCE_W-1:0]  cnt_q, cnt_d;
  logic [DEBOUNCE_W-1:0]  thresh_q;
  logic [CW-1:0]          thr_eff;
  logic [CW-1:0]          cnt_inc;
  logic                   trig_d, rise_d, fall_d;
  logic [7:0]             glitch_d;
  logic [9:0]             pending_q;
  logic                   pend_vld_q;
  logic                   apply_c;

  assign s       = sync_q[SYNC_STAGES-1];
  assign thr_eff = (thresh_q == '0) ? CW'(1) : CW'(thresh_q);
  assign cnt_inc = CW'(cnt_q) + CW'(1);
  assign apply_c = pend_vld_q && ((state_q == IDLE_LO) || (state_q == IDLE_HI));

  // Synchroniser chain and debounce threshold register
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      sync_q   <= '0;
      thresh_q <= DEBOUNCE_W'(DEFAULT_DB);
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_trig_raw};
      if (i_db_load) thresh_q <= i_db_count;
    end
  end

  // Debounce FSM state and registered outputs
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q      <= IDLE_LO;
      cnt_q        <= '0;
      o_TRIG       <= 1'b0;
      o_trig_rise  <= 1'b0;
      o_trig_fall  <= 1'b0;
      o_glitch_cnt <= 8'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      o_TRIG       <= trig_d;
      o_trig_rise  <= rise_d;
      o_trig_fall  <= fall_d;
      o_glitch_cnt <= glitch_d;
    end
  end

  // Next-state logic: qualify a level change for thresh cycles or abort as a glitch
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    trig_d   = o_TRIG;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = o_glitch_cnt;
    case (state_q)
      IDLE_LO: begin
        if (s) begin
          if (CW'(1) >= thr_eff) begin
            trig_d  = 1'b1;
            rise_d  = 1'b1;
            state_d = IDLE_HI;
            cnt_d   = '0;
          end else begin
            state_d = QUAL_HI;
            cnt_d   = DEBOUNCE_W'(1);
          end
        end
      end
      IDLE_HI: begin
        if (!s) begin
          if (CW'(1) >= thr_eff) begin
            trig_d  = 1'b0;
            fall_d  = 1'b1;
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else begin
            state_d = QUAL_LO;
            cnt_d   = DEBOUNCE_W'(1);
          end
        end
      end
      QUAL_HI: begin
        if (s) begin
          if (cnt_inc >= thr_eff) begin
            trig_d  = 1'b1;
            rise_d  = 1'b1;
            state_d = IDLE_HI;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[DEBOUNCE_W-1:0];
          end
        end else begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          if (o_glitch_cnt != 8'hFF) glitch_d = o_glitch_cnt + 8'd1;
        end
      end
      QUAL_LO: begin
        if (!s) begin
          if (cnt_inc >= thr_eff) begin
            trig_d  = 1'b0;
            fall_d  = 1'b1;
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc[DEBOUNCE_W-1:0];
          end
        end else begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          if (o_glitch_cnt != 8'hFF) glitch_d = o_glitch_cnt + 8'd1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Config capture into pending, applied only at idle edges (older value wins a tie)
  always_ff @(posedge clk or negedge RESET_n) begin
    if (!RESET_n) begin
      pending_q  <= '0;
      pend_vld_q <= 1'b0;
      o_wb       <= 8'd0;
      o_A        <= 1'b0;
      o_B        <= 1'b0;
    end else begin
      if (apply_c) begin
        o_wb       <= pending_q[9:2];
        o_A        <= pending_q[1];
        o_B        <= pending_q[0];
        pend_vld_q <= 1'b0;
      end
      if (i_prog_strobe) begin
        pending_q  <= {i_prog_wb, i_prog_ab};
        pend_vld_q <= 1'b1;
      end
    end
  end

endmodule
